multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath (pc, npc, im, GPR, ext, alu, dm).
//  Replaces single-cycle decode with FSM IF->ID->EX->MEM->WB.
//  Drives all datapath select and strobe lines from current state plus latched IR op/funct.
//  Handles a ready handshake to the shared memory port.
// PARAMETERS
//  WAIT_MAX  15  max wait cycles for mem_rdy before abort; counter width = $clog2(WAIT_MAX+1)
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  op         in   6  IR[31:26], stable from ID onward
//  funct      in   6  IR[5:0]
//  zero       in   1  alu zero flag
//  overflow   in   1  alu overflow flag
//  mem_rdy    in   1  memory port done (read data valid / write accepted)
//  pc_wr      out  1  pc load strobe
//  npc_sel    out  3  000 pc+4, 001 beq target, 010 j/jal, 011 jr (busA)
//  ir_wr      out  1  IR load strobe
//  reg_dst    out  2  00 rt, 01 rd, 10 $31
//  alu_src    out  1  0 busB, 1 ext
//  ext_sel    out  2  00 zero-ext, 01 sign-ext, 10 imm<<16
//  alu_sel    out  2  00 add, 01 sub, 10 or
//  wd_sel     out  2  00 alu, 01 dm, 10 pc (link), 11 {31'b0,less_than}
//  reg_write  out  1  GPR write strobe
//  mem_read   out  1  memory read request (IF fetch or lw)
//  mem_write  out  1  memory write request (sw)
//  illegal    out  1  1-cycle pulse in ID on undecoded op/funct
//  bus_err    out  1  1-cycle pulse on mem_rdy timeout
// BEHAVIOUR
//  - Reset: state=S_IF, wait_cnt=0; pc_wr/ir_wr/reg_write/mem_write/illegal/bus_err=0.
//    Selects=0. mem_read=1 (S_IF).
//  - Outputs are combinational from state and op/funct; only state, wait_cnt and perf
//    counters are registered.
//  - S_IF: mem_read=1. On mem_rdy: ir_wr=1, pc_wr=1, npc_sel=000 -> S_ID.
//  - S_ID, decode op/funct:
//    j: pc_wr, npc_sel=010 -> S_IF.
//    jal: same, plus reg_write, reg_dst=10, wd_sel=10 (pc already = pc+4) -> S_IF.
//    jr (op 0, funct 001000): pc_wr, npc_sel=011 -> S_IF.
//    Undecoded: illegal=1 -> S_IF (executes as NOP). Else -> S_EX.
//  - S_EX:
//    beq: alu_sel=01, pc_wr=zero, npc_sel=001 -> S_IF.
//    lw/sw: alu_src=1, ext_sel=01, alu_sel=00 -> S_MEM.
//    addu/subu/slt/ori/lui/addi -> S_WB.
//  - S_MEM (selects held from EX):
//    lw: mem_read; on mem_rdy -> S_WB.
//    sw: mem_write; on mem_rdy -> S_IF.
//  - S_WB, one cycle, reg_write=1:
//    R-type: reg_dst=01. ori: ext_sel=00, alu_sel=10.
//    lui: ext_sel=10, alu_sel=10 with rs=$0. slt: wd_sel=11, alu_sel=01.
//    addi: sign-ext, add; reg_write=0 if overflow. lw: wd_sel=01, reg_dst=00.
//    -> S_IF.
//  - Wait counter: cleared on entry to S_IF/S_MEM, increments each cycle mem_rdy=0.
//    At wait_cnt==WAIT_MAX with mem_rdy=0: bus_err=1, no strobes, -> S_IF.
//    PC is not advanced, so the fetch retries.
//  - mem_rdy in the same cycle as timeout: completion wins, no bus_err.
//  - mem_rdy outside S_IF/S_MEM: ignored.
//  - rst mid-instruction: immediate return to S_IF, partial instruction discarded.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
//    Both reset to 0 and wrap at 2^32.
//    cycle_cnt +1 every cycle.
//    instr_cnt +1 on every transition into S_IF except bus_err aborts.
//  MC_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  mc_pkg:
//    opcode/funct constants (R 000000, addu 100001, subu 100011, slt 101010,
//      jr 001000, ori 001101, lui 001111, addi 001000, lw 100011, sw 101011,
//      beq 000100, j 000010, jal 000011).
//    State encoding S_IF..S_WB (3 bits).
//    npc_sel/reg_dst/wd_sel/ext_sel/alu_sel encodings.
//  Sub-module mc_decode: combinational op/funct -> one-hot instruction class + illegal.
// TESTING
//  - addu $3,$1,$2, mem_rdy immediate: IF,ID,EX,WB = 4 cycles;
//    WB has reg_write=1, reg_dst=01, wd_sel=00.
//  - lw with mem_rdy delayed 3 cycles in MEM: mem_read held 4 cycles;
//    WB wd_sel=01; total 8 cycles.
//  - beq: zero=1 -> pc_wr=1, npc_sel=001 in EX; zero=0 -> pc_wr=0; next state S_IF.
//  - jal: in ID, pc_wr=1, npc_sel=010, reg_write=1, reg_dst=10, wd_sel=10; 2 cycles total.
//  - addi with overflow=1 in WB: reg_write=0; op=111111: illegal pulse, back to S_IF.
//  - mem_rdy held 0 in S_IF for 16 cycles: bus_err pulse, pc_wr never asserted.
//    rst mid-MEM: next cycle state=S_IF, mem_write=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs,
// FSM states, datapath select codes and the decoded instruction class.
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_BEQ  = 3'b001;
    localparam logic [2:0] NPC_J    = 3'b010;
    localparam logic [2:0] NPC_JR   = 3'b011;

    localparam logic [1:0] RDST_RT  = 2'b00;
    localparam logic [1:0] RDST_RD  = 2'b01;
    localparam logic [1:0] RDST_31  = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC    = 2'b10;
    localparam logic [1:0] WD_LT    = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HI16 = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    typedef struct packed {
        logic addu;
        logic subu;
        logic slt;
        logic jr;
        logic ori;
        logic lui;
        logic addi;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the sequencer, slave the datapath side.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       mem_rdy;
    logic       pc_wr;
    logic [2:0] npc_sel;
    logic       ir_wr;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] ext_sel;
    logic [1:0] alu_sel;
    logic [1:0] wd_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  op, funct, zero, overflow, mem_rdy,
        output pc_wr, npc_sel, ir_wr, reg_dst, alu_src, ext_sel, alu_sel,
               wd_sel, reg_write, mem_read, mem_write, illegal, bus_err
    );

    modport slave (
        output op, funct, zero, overflow, mem_rdy,
        input  pc_wr, npc_sel, ir_wr, reg_dst, alu_src, ext_sel, alu_sel,
               wd_sel, reg_write, mem_read, mem_write, illegal, bus_err
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational decode of op/funct into a one-hot instruction class; all-zero class is illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_t    cls_o,
    output logic       illegal_o
);
    always_comb begin
        cls_o = '0;
        unique case (op_i)
            OP_R: begin
                unique case (funct_i)
                    FN_ADDU: cls_o.addu = 1'b1;
                    FN_SUBU: cls_o.subu = 1'b1;
                    FN_SLT:  cls_o.slt  = 1'b1;
                    FN_JR:   cls_o.jr   = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls_o.ori  = 1'b1;
            OP_LUI:  cls_o.lui  = 1'b1;
            OP_ADDI: cls_o.addi = 1'b1;
            OP_LW:   cls_o.lw   = 1'b1;
            OP_SW:   cls_o.sw   = 1'b1;
            OP_BEQ:  cls_o.beq  = 1'b1;
            OP_J:    cls_o.j    = 1'b1;
            OP_JAL:  cls_o.jal  = 1'b1;
            default: ;
        endcase
        illegal_o = (cls_o == '0);
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS datapath with memory ready timeout.
// Define MC_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counter outputs.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt
`endif
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    iclass_t          cls;
    logic             undecoded;
    logic             mem_phase;
    logic             timeout;
    logic             path_src;
    logic [1:0]       path_ext;
    logic [1:0]       path_alu;

    mc_decode u_decode (
        .op_i      (bus.op),
        .funct_i   (bus.funct),
        .cls_o     (cls),
        .illegal_o (undecoded)
    );

    assign mem_phase = (state_q == S_IF) || (state_q == S_MEM);
    // A ready arriving on the last allowed cycle still completes the access.
    assign timeout   = mem_phase && !bus.mem_rdy && (wait_q == CNT_W'(WAIT_MAX));

    // ALU operand/operation selects for the latched instruction, shared by EX, MEM and WB.
    always_comb begin
        path_src = 1'b0;
        path_ext = EXT_ZERO;
        path_alu = ALU_ADD;
        if (cls.lw || cls.sw || cls.addi) begin
            path_src = 1'b1;
            path_ext = EXT_SIGN;
        end else if (cls.ori) begin
            path_src = 1'b1;
            path_alu = ALU_OR;
        end else if (cls.lui) begin
            path_src = 1'b1;
            path_ext = EXT_HI16;
            path_alu = ALU_OR;
        end else if (cls.subu || cls.slt || cls.beq) begin
            path_alu = ALU_SUB;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.pc_wr     = 1'b0;
        bus.npc_sel   = NPC_PC4;
        bus.ir_wr     = 1'b0;
        bus.reg_dst   = RDST_RT;
        bus.alu_src   = 1'b0;
        bus.ext_sel   = EXT_ZERO;
        bus.alu_sel   = ALU_ADD;
        bus.wd_sel    = WD_ALU;
        bus.reg_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.illegal   = 1'b0;
        bus.bus_err   = 1'b0;
        unique case (state_q)
            S_IF: begin
                bus.mem_read = 1'b1;
                if (bus.mem_rdy) begin
                    bus.ir_wr = 1'b1;
                    bus.pc_wr = 1'b1;
                    state_d   = S_ID;
                end else if (timeout) begin
                    bus.bus_err = 1'b1;
                end
            end
            S_ID: begin
                if (cls.j || cls.jal) begin
                    bus.pc_wr   = 1'b1;
                    bus.npc_sel = NPC_J;
                    if (cls.jal) begin
                        bus.reg_write = 1'b1;
                        bus.reg_dst   = RDST_31;
                        bus.wd_sel    = WD_PC;
                    end
                    state_d = S_IF;
                end else if (cls.jr) begin
                    bus.pc_wr   = 1'b1;
                    bus.npc_sel = NPC_JR;
                    state_d     = S_IF;
                end else if (undecoded) begin
                    bus.illegal = 1'b1;
                    state_d     = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                bus.alu_src = path_src;
                bus.ext_sel = path_ext;
                bus.alu_sel = path_alu;
                if (cls.beq) begin
                    bus.pc_wr   = bus.zero;
                    bus.npc_sel = NPC_BEQ;
                    state_d     = S_IF;
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.alu_src   = path_src;
                bus.ext_sel   = path_ext;
                bus.alu_sel   = path_alu;
                bus.mem_read  = cls.lw;
                bus.mem_write = cls.sw;
                if (bus.mem_rdy) begin
                    state_d = cls.lw ? S_WB : S_IF;
                end else if (timeout) begin
                    bus.bus_err = 1'b1;
                    state_d     = S_IF;
                end
            end
            S_WB: begin
                bus.alu_src   = path_src;
                bus.ext_sel   = path_ext;
                bus.alu_sel   = path_alu;
                bus.reg_write = cls.addi ? !bus.overflow : 1'b1;
                if (cls.addu || cls.subu || cls.slt) bus.reg_dst = RDST_RD;
                if (cls.slt) bus.wd_sel = WD_LT;
                if (cls.lw)  bus.wd_sel = WD_DM;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Counter restarts whenever a memory phase is (re)entered, including an abort retry.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || bus.bus_err) begin
            wait_d = '0;
        end else if (mem_phase && !bus.mem_rdy) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if ((state_d == S_IF) && (state_q != S_IF) && !bus.bus_err) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected controls are queued by the
// stimulus and compared under a field mask by a negedge monitor.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    typedef struct packed {
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic       ir_wr;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] ext_sel;
        logic [1:0] alu_sel;
        logic [1:0] wd_sel;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus_if ();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_ctrl #(.WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    logic [18:0] exp_q[$];
    logic [18:0] msk_q[$];
    string       nm_q[$];
    int          checks = 0;
    int          errors = 0;
    outs_t       e, m;

    function automatic outs_t sample();
        outs_t s;
        s.pc_wr     = bus_if.pc_wr;
        s.npc_sel   = bus_if.npc_sel;
        s.ir_wr     = bus_if.ir_wr;
        s.reg_dst   = bus_if.reg_dst;
        s.alu_src   = bus_if.alu_src;
        s.ext_sel   = bus_if.ext_sel;
        s.alu_sel   = bus_if.alu_sel;
        s.wd_sel    = bus_if.wd_sel;
        s.reg_write = bus_if.reg_write;
        s.mem_read  = bus_if.mem_read;
        s.mem_write = bus_if.mem_write;
        s.illegal   = bus_if.illegal;
        s.bus_err   = bus_if.bus_err;
        return s;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [18:0] ev, mv, av;
            string nm;
            ev = exp_q.pop_front();
            mv = msk_q.pop_front();
            nm = nm_q.pop_front();
            av = sample();
            checks++;
            if ((av & mv) !== (ev & mv)) begin
                errors++;
                $display("FAIL %s: got %05h required %05h (mask %05h)", nm, av & mv, ev & mv, mv);
            end
        end
    end

    // Strobes are always checked; selects only where a test sets their mask.
    task automatic clr();
        e = '0;
        m = '0;
        m.pc_wr = 1'b1; m.ir_wr = 1'b1; m.reg_write = 1'b1; m.mem_read = 1'b1;
        m.mem_write = 1'b1; m.illegal = 1'b1; m.bus_err = 1'b1;
    endtask

    task automatic step(input string nm, input logic rdy);
        bus_if.mem_rdy = rdy;
        exp_q.push_back(e);
        msk_q.push_back(m);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm, input logic [5:0] o, input logic [5:0] f);
        bus_if.op = o;
        bus_if.funct = f;
        clr();
        e.mem_read = 1'b1; e.pc_wr = 1'b1; e.ir_wr = 1'b1;
        e.npc_sel = NPC_PC4; m.npc_sel = 3'b111;
        step({nm, "_if"}, 1'b1);
    endtask

    task automatic idle(input string nm, input logic rdy);
        clr();
        step(nm, rdy);
    endtask

    task automatic ld_st_sel();
        e.alu_src = 1'b1; m.alu_src = 1'b1;
        e.ext_sel = EXT_SIGN; m.ext_sel = 2'b11;
        e.alu_sel = ALU_ADD; m.alu_sel = 2'b11;
    endtask

    task automatic wb(input string nm, input logic [1:0] rdst, input logic [1:0] wd, input logic rw);
        clr();
        e.reg_write = rw;
        e.reg_dst = rdst; m.reg_dst = 2'b11;
        e.wd_sel = wd; m.wd_sel = 2'b11;
        step(nm, 1'b0);
    endtask

    initial begin
        bus_if.op = '0; bus_if.funct = '0; bus_if.zero = 1'b0;
        bus_if.overflow = 1'b0; bus_if.mem_rdy = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset: IF with only mem_read, every select zero.
        for (int i = 0; i < 2; i++) begin
            e = '0; m = '1; e.mem_read = 1'b1;
            step("reset", 1'b0);
        end
        rst = 1'b0;

        // addu: IF, ID, EX, WB
        fetch("addu", OP_R, FN_ADDU);
        idle("addu_id", 1'b0);
        idle("addu_ex", 1'b0);
        wb("addu_wb", RDST_RD, WD_ALU, 1'b1);

        // subu with mem_rdy held high outside memory phases
        fetch("subu", OP_R, FN_SUBU);
        idle("subu_id", 1'b1);
        clr(); e.alu_sel = ALU_SUB; m.alu_sel = 2'b11; step("subu_ex", 1'b1);
        wb("subu_wb", RDST_RD, WD_ALU, 1'b1);

        // lw with 3 wait cycles in MEM: 8 cycles total
        fetch("lw", OP_LW, 6'd0);
        idle("lw_id", 1'b0);
        clr(); ld_st_sel(); step("lw_ex", 1'b0);
        for (int i = 0; i < 3; i++) begin
            clr(); ld_st_sel(); e.mem_read = 1'b1; step("lw_mem_wait", 1'b0);
        end
        clr(); ld_st_sel(); e.mem_read = 1'b1; step("lw_mem_done", 1'b1);
        wb("lw_wb", RDST_RT, WD_DM, 1'b1);

        // sw completes immediately
        fetch("sw", OP_SW, 6'd0);
        idle("sw_id", 1'b0);
        clr(); ld_st_sel(); step("sw_ex", 1'b0);
        clr(); ld_st_sel(); e.mem_write = 1'b1; step("sw_mem", 1'b1);

        // beq taken / not taken
        for (int z = 1; z >= 0; z--) begin
            fetch("beq", OP_BEQ, 6'd0);
            idle("beq_id", 1'b0);
            bus_if.zero = z[0];
            clr(); e.pc_wr = z[0]; e.npc_sel = NPC_BEQ; m.npc_sel = 3'b111;
            e.alu_sel = ALU_SUB; m.alu_sel = 2'b11;
            step(z[0] ? "beq_ex_taken" : "beq_ex_not_taken", 1'b0);
            bus_if.zero = 1'b0;
        end

        // jal / j / jr resolve in ID
        fetch("jal", OP_JAL, 6'd0);
        clr(); e.pc_wr = 1'b1; e.npc_sel = NPC_J; m.npc_sel = 3'b111;
        e.reg_write = 1'b1; e.reg_dst = RDST_31; m.reg_dst = 2'b11;
        e.wd_sel = WD_PC; m.wd_sel = 2'b11;
        step("jal_id", 1'b0);
        fetch("j", OP_J, 6'd0);
        clr(); e.pc_wr = 1'b1; e.npc_sel = NPC_J; m.npc_sel = 3'b111; step("j_id", 1'b0);
        fetch("jr", OP_R, FN_JR);
        clr(); e.pc_wr = 1'b1; e.npc_sel = NPC_JR; m.npc_sel = 3'b111; step("jr_id", 1'b0);

        // ori, lui, slt write-back selects
        fetch("ori", OP_ORI, 6'd0);
        idle("ori_id", 1'b0);
        idle("ori_ex", 1'b0);
        clr(); e.reg_write = 1'b1; e.ext_sel = EXT_ZERO; m.ext_sel = 2'b11;
        e.alu_sel = ALU_OR; m.alu_sel = 2'b11; step("ori_wb", 1'b0);
        fetch("lui", OP_LUI, 6'd0);
        idle("lui_id", 1'b0);
        idle("lui_ex", 1'b0);
        clr(); e.reg_write = 1'b1; e.ext_sel = EXT_HI16; m.ext_sel = 2'b11;
        e.alu_sel = ALU_OR; m.alu_sel = 2'b11; step("lui_wb", 1'b0);
        fetch("slt", OP_R, FN_SLT);
        idle("slt_id", 1'b0);
        idle("slt_ex", 1'b0);
        clr(); e.reg_write = 1'b1; e.wd_sel = WD_LT; m.wd_sel = 2'b11;
        e.alu_sel = ALU_SUB; m.alu_sel = 2'b11; e.reg_dst = RDST_RD; m.reg_dst = 2'b11;
        step("slt_wb", 1'b0);

        // addi: overflow suppresses the write
        for (int v = 1; v >= 0; v--) begin
            fetch("addi", OP_ADDI, 6'd0);
            idle("addi_id", 1'b0);
            idle("addi_ex", 1'b0);
            bus_if.overflow = v[0];
            clr(); e.reg_write = !v[0]; step(v[0] ? "addi_wb_ovf" : "addi_wb_ok", 1'b0);
            bus_if.overflow = 1'b0;
        end

        // undecoded op and undecoded R-type funct
        fetch("ill_op", 6'b111111, 6'd0);
        clr(); e.illegal = 1'b1; step("ill_op_id", 1'b0);
        fetch("ill_fn", OP_R, 6'b000000);
        clr(); e.illegal = 1'b1; step("ill_fn_id", 1'b0);

        // IF timeout: 15 wait cycles then bus_err on the 16th, no pc_wr
        for (int i = 0; i < 15; i++) begin
            clr(); e.mem_read = 1'b1; step("to_wait", 1'b0);
        end
        clr(); e.bus_err = 1'b1; m.mem_read = 1'b0; step("to_abort", 1'b0);
        // Retry: ready on the last allowed cycle completes without bus_err
        for (int i = 0; i < 15; i++) begin
            clr(); e.mem_read = 1'b1; step("retry_wait", 1'b0);
        end
        fetch("retry_last", OP_R, FN_ADDU);
        idle("retry_id", 1'b0);
        idle("retry_ex", 1'b0);
        wb("retry_wb", RDST_RD, WD_ALU, 1'b1);

        // rst mid-MEM of a store
        fetch("swr", OP_SW, 6'd0);
        idle("swr_id", 1'b0);
        clr(); ld_st_sel(); step("swr_ex", 1'b0);
        clr(); ld_st_sel(); e.mem_write = 1'b1; step("swr_mem", 1'b0);
        rst = 1'b1;
        e = '0; m = '1; e.mem_read = 1'b1; step("rst_mid_mem", 1'b0);
        rst = 1'b0;
        fetch("after_rst", OP_J, 6'd0);
        clr(); e.pc_wr = 1'b1; e.npc_sel = NPC_J; m.npc_sel = 3'b111; step("after_rst_id", 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
